// File: rtl/audio_stream_scheduler.sv
// rtl/audio_stream_scheduler.sv - sequences one-sector SD loads into the audio sample FIFO for a single track
module audio_stream_scheduler #(
  parameter int FIFO_DEPTH   = 4096,
  parameter int CNT_W        = 13,
  parameter int SECTOR_BYTES = 512
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             play,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [31:0]      track_addr,
  input  logic [15:0]      track_sectors,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             sd_ready,
  input  logic             fifo_write_enable,
  output logic             load_fifo,
  output logic [31:0]      read_addr,
  output logic             busy,
  output logic             track_done,
  output logic [15:0]      sectors_left
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROOM,
    LOAD,
    FILL,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] ROOM_LIMIT  = CNT_W'(FIFO_DEPTH - SECTOR_BYTES);
  localparam logic [9:0]       LAST_BYTE   = 10'(SECTOR_BYTES - 1);
  localparam logic [31:0]      SECTOR_STEP = 32'(SECTOR_BYTES);

  state_t      state;
  state_t      next_state;
  logic [9:0]  byte_cnt;
  logic        stop_flag;
  logic [31:0] base_addr;
  logic [15:0] base_sectors;

  logic start_ok;
  logic start_empty;
  logic stop_req;
  logic last_strobe;
  logic last_sector;
  logic has_room;

  assign start_ok    = (state == IDLE) && play && (track_sectors != 16'd0);
  assign start_empty = (state == IDLE) && play && (track_sectors == 16'd0);
  // A stop arriving in WAIT_ROOM itself is honoured without launching one more sector.
  assign stop_req    = stop_flag || stop;
  assign last_strobe = (state == FILL) && fifo_write_enable && (byte_cnt == LAST_BYTE);
  assign last_sector = (sectors_left == 16'd1);
  assign has_room    = (fifo_count <= ROOM_LIMIT) && sd_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) next_state = WAIT_ROOM;
      end
      WAIT_ROOM: begin
        if (stop_req)      next_state = FINISH;
        else if (has_room) next_state = LOAD;
      end
      LOAD: begin
        next_state = FILL;
      end
      FILL: begin
        if (last_strobe) begin
          if (last_sector && !loop_en) next_state = FINISH;
          else                         next_state = WAIT_ROOM;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= IDLE;
      load_fifo    <= 1'b0;
      busy         <= 1'b0;
      track_done   <= 1'b0;
      read_addr    <= 32'd0;
      sectors_left <= 16'd0;
      byte_cnt     <= 10'd0;
      stop_flag    <= 1'b0;
      base_addr    <= 32'd0;
      base_sectors <= 16'd0;
    end else begin
      state      <= next_state;
      // Outputs are registered from next_state so they line up with the state they describe.
      load_fifo  <= (next_state == LOAD);
      busy       <= (next_state != IDLE);
      track_done <= (next_state == FINISH) || start_empty;

      if (start_ok) begin
        base_addr    <= track_addr;
        base_sectors <= track_sectors;
        read_addr    <= track_addr;
        sectors_left <= track_sectors;
        stop_flag    <= 1'b0;
      end else if ((state != IDLE) && stop) begin
        stop_flag <= 1'b1;
      end

      if (state == LOAD) begin
        byte_cnt <= 10'd0;
      end else if ((state == FILL) && fifo_write_enable) begin
        byte_cnt <= byte_cnt + 10'd1;
      end

      if (last_strobe) begin
        if (last_sector && loop_en) begin
          read_addr    <= base_addr;
          sectors_left <= base_sectors;
        end else begin
          read_addr    <= read_addr + SECTOR_STEP;
          sectors_left <= sectors_left - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_scheduler.sv
// tb/tb_audio_stream_scheduler.sv - randomized self-checking bench for audio_stream_scheduler
module tb_audio_stream_scheduler;

  localparam int FIFO_DEPTH   = 4096;
  localparam int CNT_W        = 13;
  localparam int SECTOR_BYTES = 512;
  localparam int RUN_BUDGET   = 40000;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic             play;
  logic             stop;
  logic             loop_en;
  logic [31:0]      track_addr;
  logic [15:0]      track_sectors;
  logic [CNT_W-1:0] fifo_count;
  logic             sd_ready;
  logic             fifo_write_enable;
  logic             load_fifo;
  logic [31:0]      read_addr;
  logic             busy;
  logic             track_done;
  logic [15:0]      sectors_left;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ld_remaining = 0;
  int strobes = 0;
  int done_cnt = 0;
  logic [31:0] got_addr[$];
  int          got_cyc[$];
  bit gaps = 1'b0;
  bit rand_env = 1'b0;
  bit noise_play = 1'b0;

  always #5 clk_in = ~clk_in;

  audio_stream_scheduler #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W),
    .SECTOR_BYTES(SECTOR_BYTES)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .play             (play),
    .stop             (stop),
    .loop_en          (loop_en),
    .track_addr       (track_addr),
    .track_sectors    (track_sectors),
    .fifo_count       (fifo_count),
    .sd_ready         (sd_ready),
    .fifo_write_enable(fifo_write_enable),
    .load_fifo        (load_fifo),
    .read_addr        (read_addr),
    .busy             (busy),
    .track_done       (track_done),
    .sectors_left     (sectors_left)
  );

  // Reference: the k-th load of a track starting at base with n sectors.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k, input int n,
                                           input bit looping);
    int idx;
    idx = looping ? (k % n) : k;
    return base + 32'(idx * SECTOR_BYTES);
  endfunction

  // One cycle: observe outputs at the falling edge, then model the loader and environment.
  task automatic step();
    @(negedge clk_in);
    cyc++;
    if (load_fifo === 1'b1) begin
      got_addr.push_back(read_addr);
      got_cyc.push_back(cyc);
    end
    if (track_done === 1'b1) done_cnt++;
    play = 1'b0;
    stop = 1'b0;
    if (ld_remaining > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      fifo_write_enable = 1'b1;
      ld_remaining--;
      strobes++;
    end else begin
      fifo_write_enable = 1'b0;
    end
    if (load_fifo === 1'b1) ld_remaining = SECTOR_BYTES;
    if (rand_env) begin
      fifo_count = CNT_W'($urandom_range(0, FIFO_DEPTH - SECTOR_BYTES));
      sd_ready   = ($urandom_range(0, 3) != 0);
    end
    if (noise_play && busy === 1'b1 && $urandom_range(0, 63) == 0) begin
      play          = 1'b1;
      track_addr    = $urandom;
      track_sectors = 16'($urandom_range(0, 9));
    end
  endtask

  task automatic clear_sb();
    got_addr.delete();
    got_cyc.delete();
    done_cnt = 0;
    strobes  = 0;
  endtask

  task automatic start_track(input logic [31:0] addr, input logic [15:0] n);
    track_addr    = addr;
    track_sectors = n;
    play          = 1'b1;
    step();
  endtask

  task automatic run_track(input string name);
    int i;
    for (i = 0; i < RUN_BUDGET; i++) begin
      step();
      if (busy === 1'b0 && ld_remaining == 0) break;
    end
    checks++;
    if (i >= RUN_BUDGET) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, i);
    end
  endtask

  task automatic test_reset();
    reset_in          = 1'b1;
    play              = 1'b0;
    stop              = 1'b0;
    loop_en           = 1'b0;
    track_addr        = 32'd0;
    track_sectors     = 16'd0;
    fifo_count        = '0;
    sd_ready          = 1'b1;
    fifo_write_enable = 1'b0;
    repeat (3) step();
    reset_in = 1'b0;
    checks++;
    if (load_fifo !== 1'b0) begin errors++; $display("FAIL reset_load_fifo: got %b required 0", load_fifo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (track_done !== 1'b0) begin errors++; $display("FAIL reset_track_done: got %b required 0", track_done); end
    checks++;
    if (read_addr !== 32'd0) begin errors++; $display("FAIL reset_read_addr: got %h required 0", read_addr); end
    checks++;
    if (sectors_left !== 16'd0) begin errors++; $display("FAIL reset_sectors_left: got %0d required 0", sectors_left); end
    step();
  endtask

  task automatic test_basic();
    int p;
    logic [31:0] a;
    clear_sb();
    gaps = 1'b1;
    fifo_count = '0;
    sd_ready = 1'b1;
    p = cyc;
    start_track(32'h1000, 16'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b required 1", busy); end
    checks++;
    if (read_addr !== 32'h1000) begin errors++; $display("FAIL basic_addr_early: got %h required 00001000", read_addr); end
    checks++;
    if (sectors_left !== 16'd3) begin errors++; $display("FAIL basic_sectors_start: got %0d required 3", sectors_left); end
    run_track("basic");
    checks++;
    if (got_addr.size() != 3) begin errors++; $display("FAIL basic_loads: got %0d required 3", got_addr.size()); end
    for (int k = 0; k < 3; k++) begin
      a = (k < got_addr.size()) ? got_addr[k] : 'x;
      checks++;
      if (a !== exp_addr(32'h1000, k, 3, 1'b0)) begin
        errors++;
        $display("FAIL basic_addr%0d: got %h required %h", k, a, exp_addr(32'h1000, k, 3, 1'b0));
      end
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - p != 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 2", (got_cyc.size() == 0) ? -1 : got_cyc[0] - p);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d required 1", done_cnt); end
    checks++;
    if (strobes != 3 * SECTOR_BYTES) begin errors++; $display("FAIL basic_strobes: got %0d required %0d", strobes, 3 * SECTOR_BYTES); end
    checks++;
    if (sectors_left !== 16'd0) begin errors++; $display("FAIL basic_sectors_end: got %0d required 0", sectors_left); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b required 0", busy); end
  endtask

  task automatic test_room();
    clear_sb();
    fifo_count = CNT_W'(FIFO_DEPTH - SECTOR_BYTES + 1);
    sd_ready = 1'b1;
    start_track(32'h1000, 16'd2);
    repeat (20) step();
    checks++;
    if (got_addr.size() != 0) begin errors++; $display("FAIL room_blocked: got %0d loads required 0", got_addr.size()); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL room_busy: got %b required 1", busy); end
    fifo_count = CNT_W'(FIFO_DEPTH - SECTOR_BYTES);
    step();
    checks++;
    if (load_fifo !== 1'b1) begin errors++; $display("FAIL room_release: got %b required 1", load_fifo); end
    run_track("room");
    checks++;
    if (got_addr.size() != 2) begin errors++; $display("FAIL room_loads: got %0d required 2", got_addr.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL room_done: got %0d required 1", done_cnt); end
    fifo_count = '0;
  endtask

  task automatic test_loop();
    logic [31:0] a;
    int i;
    clear_sb();
    loop_en = 1'b1;
    start_track(32'h1000, 16'd2);
    for (i = 0; i < RUN_BUDGET && got_addr.size() < 4; i++) step();
    checks++;
    if (got_addr.size() < 4) begin errors++; $display("FAIL loop_timeout: got %0d loads required 4", got_addr.size()); end
    for (int k = 0; k < 4; k++) begin
      a = (k < got_addr.size()) ? got_addr[k] : 'x;
      checks++;
      if (a !== exp_addr(32'h1000, k, 2, 1'b1)) begin
        errors++;
        $display("FAIL loop_addr%0d: got %h required %h", k, a, exp_addr(32'h1000, k, 2, 1'b1));
      end
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL loop_no_done: got %0d required 0", done_cnt); end
    stop = 1'b1;
    run_track("loop_stop");
    checks++;
    if (got_addr.size() != 4) begin errors++; $display("FAIL loop_stop_loads: got %0d required 4", got_addr.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL loop_stop_done: got %0d required 1", done_cnt); end
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int i;
    clear_sb();
    start_track(32'h1000, 16'd4);
    for (i = 0; i < RUN_BUDGET; i++) begin
      step();
      if (got_addr.size() == 1 && ld_remaining <= SECTOR_BYTES - 100) break;
    end
    stop = 1'b1;
    run_track("stop");
    checks++;
    if (got_addr.size() != 1) begin errors++; $display("FAIL stop_loads: got %0d required 1", got_addr.size()); end
    checks++;
    if (strobes != SECTOR_BYTES) begin errors++; $display("FAIL stop_strobes: got %0d required %0d", strobes, SECTOR_BYTES); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL stop_done: got %0d required 1", done_cnt); end
    checks++;
    if (sectors_left !== 16'd3) begin errors++; $display("FAIL stop_sectors_left: got %0d required 3", sectors_left); end
    checks++;
    if (read_addr !== 32'h1200) begin errors++; $display("FAIL stop_read_addr: got %h required 00001200", read_addr); end
  endtask

  task automatic test_stop_final();
    int i;
    clear_sb();
    gaps = 1'b0;
    start_track(32'h4000, 16'd1);
    for (i = 0; i < RUN_BUDGET; i++) begin
      step();
      if (ld_remaining == 0 && fifo_write_enable === 1'b1) break;
    end
    stop = 1'b1;
    run_track("stop_final");
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL stop_final_done: got %0d required 1", done_cnt); end
    checks++;
    if (got_addr.size() != 1) begin errors++; $display("FAIL stop_final_loads: got %0d required 1", got_addr.size()); end
    gaps = 1'b1;
  endtask

  task automatic test_zero();
    clear_sb();
    stop = 1'b1;
    step();
    start_track(32'h5000, 16'd0);
    checks++;
    if (track_done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b required 1", track_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
    step();
    checks++;
    if (track_done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b required 0", track_done); end
    repeat (8) step();
    checks++;
    if (got_addr.size() != 0) begin errors++; $display("FAIL zero_loads: got %0d required 0", got_addr.size()); end
    start_track(32'h2000, 16'd1);
    run_track("zero_next");
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h2000) begin
      errors++;
      $display("FAIL zero_next_load: got %0d loads required 1 at 00002000", got_addr.size());
    end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL zero_next_done: got %0d required 2", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int i;
    logic [31:0] a;
    clear_sb();
    start_track(32'h3000, 16'd3);
    for (i = 0; i < RUN_BUDGET; i++) begin
      step();
      if (got_addr.size() == 1 && ld_remaining <= SECTOR_BYTES - 300) break;
    end
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    ld_remaining = 0;
    fifo_write_enable = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_fifo !== 1'b0 || track_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got busy=%b load=%b done=%b required 0 0 0", busy, load_fifo, track_done);
    end
    checks++;
    if (read_addr !== 32'd0) begin errors++; $display("FAIL midreset_read_addr: got %h required 0", read_addr); end
    checks++;
    if (sectors_left !== 16'd0) begin errors++; $display("FAIL midreset_sectors_left: got %0d required 0", sectors_left); end
    clear_sb();
    start_track(32'h8000, 16'd2);
    run_track("midreset_restart");
    checks++;
    if (got_addr.size() != 2) begin errors++; $display("FAIL midreset_loads: got %0d required 2", got_addr.size()); end
    for (int k = 0; k < 2; k++) begin
      a = (k < got_addr.size()) ? got_addr[k] : 'x;
      checks++;
      if (a !== exp_addr(32'h8000, k, 2, 1'b0)) begin
        errors++;
        $display("FAIL midreset_addr%0d: got %h required %h", k, a, exp_addr(32'h8000, k, 2, 1'b0));
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL midreset_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [31:0] a;
    int n;
    rand_env = 1'b1;
    noise_play = 1'b1;
    for (int t = 0; t < 6; t++) begin
      clear_sb();
      base = (t == 0) ? 32'hFFFF_FC00 : ($urandom & 32'hFFFF_FE00);
      n = (t == 0) ? 4 : $urandom_range(1, 5);
      start_track(base, 16'(n));
      run_track("random");
      checks++;
      if (got_addr.size() != n) begin errors++; $display("FAIL random%0d_loads: got %0d required %0d", t, got_addr.size(), n); end
      for (int k = 0; k < n; k++) begin
        a = (k < got_addr.size()) ? got_addr[k] : 'x;
        checks++;
        if (a !== exp_addr(base, k, n, 1'b0)) begin
          errors++;
          $display("FAIL random%0d_addr%0d: got %h required %h", t, k, a, exp_addr(base, k, n, 1'b0));
        end
      end
      checks++;
      if (read_addr !== exp_addr(base, n, n, 1'b0)) begin
        errors++;
        $display("FAIL random%0d_final_addr: got %h required %h", t, read_addr, exp_addr(base, n, n, 1'b0));
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL random%0d_done: got %0d required 1", t, done_cnt); end
      checks++;
      if (sectors_left !== 16'd0) begin errors++; $display("FAIL random%0d_sectors_left: got %0d required 0", t, sectors_left); end
    end
    rand_env = 1'b0;
    noise_play = 1'b0;
    play = 1'b0;
    fifo_count = '0;
    sd_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_room();
    test_loop();
    test_stop();
    test_stop_final();
    test_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
